maxnet_accumulator: RTL and testbench

Sequential IEEE-754 single-precision accumulator that sits directly downstream of `ieee754_multiplier` in the Maxnet datapath. It takes the stream of weighted products for one neuron, one per beat: the self term x_i·1 and the inhibition terms −ε·x_j. It sums them with an internal FP adder, applies ReLU, and presents the updated activation x_i(t+1) to the neuron register file through a valid/ready handshake.

---
 rtl/maxnet_pkg.sv | 43 ++++
 rtl/ieee754_adder.sv | 92 +++++++++
 rtl/maxnet_accumulator.sv | 116 +++++++++++
 tb/tb_maxnet_accumulator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared Maxnet definitions: IEEE-754 single-precision field layout, accumulator
// FSM encoding and field helpers common to the multiplier and the accumulator.
package maxnet_pkg;

    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned FRAC_WIDTH = 23;
    localparam int unsigned BIAS       = 127;

    localparam logic [31:0] FP_ZERO = 32'h0;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_WIDTH-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [FRAC_WIDTH-1:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

    // Exponent field 0 covers +0, -0 and denormals, all of which count as zero.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return fp_exp(x) == '0;
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return fp_exp(x) == EXP_MAX;
    endfunction

    function automatic logic [31:0] fp_relu(input logic [31:0] x);
        if (fp_sign(x) || fp_is_zero(x)) begin
            return FP_ZERO;
        end
        return x;
    endfunction

endpackage

// File: rtl/ieee754_adder.sv
// Combinational single-precision adder: flush-to-zero inputs, truncating
// rounding, saturation to signed infinity with an overflow flag.
module ieee754_adder
    import maxnet_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        ovf_o
);

    logic                a_big;
    logic                big_s;
    logic [7:0]          big_e;
    logic [7:0]          sml_e;
    logic [26:0]         big_x;
    logic [26:0]         sml_x;
    logic [26:0]         sml_al;
    logic [7:0]          diff;
    logic [27:0]         raw;
    logic [26:0]         norm;
    logic [4:0]          msb;
    logic [4:0]          lz;
    logic signed [9:0]   e_res;

    assign a_big = {fp_exp(a_i), fp_frac(a_i)} >= {fp_exp(b_i), fp_frac(b_i)};
    assign big_s = a_big ? fp_sign(a_i) : fp_sign(b_i);
    assign big_e = a_big ? fp_exp(a_i) : fp_exp(b_i);
    assign sml_e = a_big ? fp_exp(b_i) : fp_exp(a_i);
    assign big_x = a_big ? {1'b1, fp_frac(a_i), 3'b000} : {1'b1, fp_frac(b_i), 3'b000};
    assign sml_x = a_big ? {1'b1, fp_frac(b_i), 3'b000} : {1'b1, fp_frac(a_i), 3'b000};
    assign diff  = big_e - sml_e;

    // Alignment keeps guard/round bits; everything shifted past them collapses into sticky.
    always_comb begin
        if (diff >= 8'd27) begin
            sml_al = {26'b0, |sml_x};
        end else begin
            sml_al = (sml_x >> diff) | {26'b0, |(sml_x & ~({27{1'b1}} << diff))};
        end
    end

    assign raw = (fp_sign(a_i) == fp_sign(b_i)) ? ({1'b0, big_x} + {1'b0, sml_al})
                                                : ({1'b0, big_x} - {1'b0, sml_al});

    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (raw[i]) begin
                msb = 5'(i);
            end
        end
    end

    assign lz = 5'd26 - msb;

    always_comb begin
        if (raw[27]) begin
            norm  = raw[27:1];
            e_res = $signed({2'b00, big_e}) + 10'sd1;
        end else begin
            norm  = raw[26:0] << lz;
            e_res = $signed({2'b00, big_e}) - $signed({5'b00000, lz});
        end
    end

    always_comb begin
        sum_o = FP_ZERO;
        ovf_o = 1'b0;
        if (fp_is_inf(a_i)) begin
            sum_o = a_i;
        end else if (fp_is_inf(b_i)) begin
            sum_o = b_i;
        end else if (fp_is_zero(a_i) && fp_is_zero(b_i)) begin
            sum_o = FP_ZERO;
        end else if (fp_is_zero(a_i)) begin
            sum_o = b_i;
        end else if (fp_is_zero(b_i)) begin
            sum_o = a_i;
        end else if (raw == '0) begin
            sum_o = FP_ZERO;
        end else if (e_res >= 10'sd255) begin
            sum_o = {big_s, EXP_MAX, 23'b0};
            ovf_o = 1'b1;
        end else if (e_res < 10'sd1) begin
            sum_o = FP_ZERO;
        end else begin
            sum_o = {big_s, e_res[7:0], norm[25:3]};
        end
    end

endmodule

// File: rtl/maxnet_accumulator.sv
// Per-neuron accumulator: sums a stream of weighted products with ieee754_adder,
// applies ReLU and hands the new activation downstream over valid/ready.
module maxnet_accumulator
    import maxnet_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_zero,
    output logic        ovf,
    output logic        term_err
);

    localparam int unsigned CW = $clog2(MAX_TERMS + 1);

    logic [0:0]    state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_zero_q, out_zero_d;
    logic          ovf_q, ovf_d;
    logic          term_err_q, term_err_d;

    logic [31:0]   add_sum;
    logic          add_ovf;
    logic [31:0]   relu_sum;
    logic [CW-1:0] cnt_inc;
    logic          beat;
    logic          hit_limit;

    ieee754_adder u_adder (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign in_ready  = (state_q == ST_ACC);
    assign beat      = in_valid && in_ready;
    assign cnt_inc   = cnt_q + CW'(1);
    assign hit_limit = (cnt_inc == CW'(MAX_TERMS));
    assign relu_sum  = fp_relu(add_sum);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        ovf_d      = ovf_q;
        term_err_d = term_err_q;
        case (state_q)
            ST_ACC: begin
                if (beat) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    if (add_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (in_last || hit_limit) begin
                        state_d    = ST_OUT;
                        out_data_d = relu_sum;
                        out_zero_d = (relu_sum == FP_ZERO);
                        // Only flag the limit when it, not in_last, closed the update.
                        term_err_d = !in_last;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d    = ST_ACC;
                    acc_d      = FP_ZERO;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    term_err_d = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            acc_q      <= FP_ZERO;
            cnt_q      <= '0;
            out_data_q <= FP_ZERO;
            out_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            term_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            ovf_q      <= ovf_d;
            term_err_q <= term_err_d;
        end
    end

    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign ovf       = ovf_q;
    assign term_err  = term_err_q;

endmodule

// File: tb/tb_maxnet_accumulator.sv
// Directed bench for maxnet_accumulator: default instance plus a MAX_TERMS=4
// instance for the term-limit path.
module tb_maxnet_accumulator;

    logic        clk;
    logic        rst_n;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_zero;
    logic        ovf;
    logic        term_err;

    logic [31:0] t_in_data;
    logic        t_in_valid;
    logic        t_in_last;
    logic        t_in_ready;
    logic [31:0] t_out_data;
    logic        t_out_valid;
    logic        t_out_ready;
    logic        t_out_zero;
    logic        t_ovf;
    logic        t_term_err;

    int unsigned total;
    int unsigned bad;

    maxnet_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_zero  (out_zero),
        .ovf       (ovf),
        .term_err  (term_err)
    );

    maxnet_accumulator #(.MAX_TERMS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (t_in_data),
        .in_valid  (t_in_valid),
        .in_last   (t_in_last),
        .in_ready  (t_in_ready),
        .out_data  (t_out_data),
        .out_valid (t_out_valid),
        .out_ready (t_out_ready),
        .out_zero  (t_out_zero),
        .ovf       (t_ovf),
        .term_err  (t_term_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        t_in_data   = '0;
        t_in_valid  = 1'b0;
        t_in_last   = 1'b0;
        t_out_ready = 1'b0;

        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_zero", {31'b0, out_zero}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_term_err", {31'b0, term_err}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // 1 - 0.25 - 0.25 = 0.5
        send(32'h3F800000, 1'b0);
        send(32'hBE800000, 1'b0);
        chk("basic_not_yet_valid", {31'b0, out_valid}, 32'd0);
        send(32'hBE800000, 1'b1);
        chk("basic_out_valid", {31'b0, out_valid}, 32'd1);
        chk("basic_in_ready", {31'b0, in_ready}, 32'd0);
        chk("basic_data", out_data, 32'h3F000000);
        chk("basic_zero", {31'b0, out_zero}, 32'd0);
        take();
        chk("basic_released", {31'b0, out_valid}, 32'd0);
        chk("basic_ready_again", {31'b0, in_ready}, 32'd1);

        // 1 - 3 = -2 clamps to +0
        send(32'h3F800000, 1'b0);
        send(32'hC0400000, 1'b1);
        chk("relu_data", out_data, 32'h0);
        chk("relu_zero", {31'b0, out_zero}, 32'd1);
        take();

        send(32'h40000000, 1'b1);
        chk("single_data", out_data, 32'h40000000);
        in_data  = 32'h3F800000;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data", out_data, 32'h40000000);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take();
        send(32'h3F800000, 1'b1);
        chk("bp_ignored_beats", out_data, 32'h3F800000);
        take();

        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        send(32'h3F000000, 1'b1);
        chk("midrst_data", out_data, 32'h3F000000);
        take();

        // 2^127 + 2^127 = 2^128 saturates
        send(32'h7F000000, 1'b0);
        send(32'h7F000000, 1'b1);
        chk("ovf_data", out_data, 32'h7F800000);
        chk("ovf_flag", {31'b0, ovf}, 32'd1);
        chk("ovf_term_err", {31'b0, term_err}, 32'd0);
        take();
        chk("ovf_cleared", {31'b0, ovf}, 32'd0);
        send(32'h3F800000, 1'b1);
        chk("post_ovf_data", out_data, 32'h3F800000);
        take();

        // 4 x 0.25 with no last on a MAX_TERMS=4 instance
        t_in_data  = 32'h3E800000;
        t_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk("limit_not_yet", {31'b0, t_out_valid}, 32'd0);
        chk("limit_still_ready", {31'b0, t_in_ready}, 32'd1);
        tick();
        t_in_valid = 1'b0;
        chk("limit_valid", {31'b0, t_out_valid}, 32'd1);
        chk("limit_data", t_out_data, 32'h3F800000);
        chk("limit_term_err", {31'b0, t_term_err}, 32'd1);
        t_out_ready = 1'b1;
        tick();
        t_out_ready = 1'b0;
        chk("limit_term_err_clr", {31'b0, t_term_err}, 32'd0);
        chk("limit_ready_again", {31'b0, t_in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
